// File: rtl/mips_pipe_pkg.sv
// Shared widths, depth bounds and control-bit positions for the MIPS
// inter-stage pipeline registers.
package mips_pipe_pkg;

    localparam int DEPTH_MIN    = 1;
    localparam int DEPTH_MAX    = 8;

    localparam int ALU_RES_W    = 32;
    localparam int MEM_VAL_W    = 32;
    localparam int DEST_W       = 4;
    localparam int PAYLOAD_W    = ALU_RES_W + MEM_VAL_W + DEST_W;

    localparam int CTRL_W_DEF   = 2;
    localparam int WB_EN_BIT    = 1;
    localparam int MEM_R_EN_BIT = 0;

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: valid/ctrl/data register with bubble zeroing and the
// local ready term that lets an empty stage absorb a downstream stall.
module pipe_stage #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 68
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    input  logic              down_ready,
    output logic              ready,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    assign ready = ~valid | down_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (ready) begin
            // An invalid upstream loads a bubble so no stale ctrl survives.
            valid <= up_valid;
            ctrl  <= up_valid ? up_ctrl : '0;
            data  <= up_valid ? up_data : '0;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse,
// synchronous flush, gated output control and an occupancy counter.
module elastic_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = PAYLOAD_W,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("elastic_pipe_reg: DEPTH out of range");
    end

    // Index 0 is the upstream port; index g+1 is the output of stage g.
    logic              v_chain [DEPTH+1];
    logic [CTRL_W-1:0] c_chain [DEPTH+1];
    logic [DATA_W-1:0] d_chain [DEPTH+1];
    // Index g is stage g's ready; index DEPTH is the downstream ready.
    logic              r_chain [DEPTH+1];

    logic in_xfer;
    logic out_xfer;

    assign v_chain[0]     = in_valid;
    assign c_chain[0]     = in_ctrl;
    assign d_chain[0]     = in_data;
    assign r_chain[DEPTH] = out_ready & ~flush;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid   (v_chain[g]),
            .up_ctrl    (c_chain[g]),
            .up_data    (d_chain[g]),
            .down_ready (r_chain[g+1]),
            .ready      (r_chain[g]),
            .valid      (v_chain[g+1]),
            .ctrl       (c_chain[g+1]),
            .data       (d_chain[g+1])
        );
    end

    assign in_ready  = ~flush & r_chain[0];
    assign out_valid = v_chain[DEPTH] & ~flush;
    assign out_ctrl  = out_valid ? c_chain[DEPTH] : '0;
    assign out_data  = d_chain[DEPTH];

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Scoreboard bench for elastic_pipe_reg: directed scenarios plus random
// traffic on a DEPTH=3 instance, and bubble checks on a DEPTH=1 instance.
module tb_elastic_pipe_reg;
    import mips_pipe_pkg::*;

    localparam int D = 3;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [67:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ctrl;
    logic [67:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ctrl;
    logic [67:0] out_data;
    logic [1:0]  occupancy;

    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [1:0]  b_in_ctrl;
    logic [67:0] b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [1:0]  b_out_ctrl;
    logic [67:0] b_out_data;
    logic [0:0]  b_occ;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    ent_t        exp_q[$];
    logic        exp_rdy;

    elastic_pipe_reg #(.CTRL_W(2), .DATA_W(68), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .occupancy(occupancy)
    );

    elastic_pipe_reg #(.CTRL_W(2), .DATA_W(68), .DEPTH(1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .occupancy(b_occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [1:0] c, input logic [67:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    // Reference: an ordered list of accepted entries; the pipe can only refuse
    // input when every stage is full and downstream is stalled.
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        check("occupancy", 128'(occupancy), 128'(exp_q.size()));
        exp_rdy = !flush && (exp_q.size() < D || out_ready);
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        if (flush) check("flush_out_valid", 128'(out_valid), 128'(0));
        if (!out_valid) begin
            check("ctrl_gate", 128'(out_ctrl), 128'(0));
        end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_out: got out_valid=1 data 0x%0h expected no entry", out_data);
        end else begin
            check("out_ctrl", 128'(out_ctrl), 128'(exp_q[0].ctrl));
            check("out_data", 128'(out_data), 128'(exp_q[0].data));
        end
        if (!rst) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (in_valid && exp_rdy) exp_q.push_back('{ctrl: in_ctrl, data: in_data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned waited;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 2'b00, '0);
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b0;

        tick();
        check("rst_out_valid", 128'(out_valid), 0);
        check("rst_out_ctrl", 128'(out_ctrl), 0);
        check("rst_out_data", 128'(out_data), 0);
        check("rst_occ", 128'(occupancy), 0);
        check("rst_in_ready", 128'(in_ready), 1);
        tick();
        rst = 1'b0;

        // Streaming with no backpressure
        out_ready = 1'b1;
        offer(1'b1, 2'b10, 68'h11); tick();
        offer(1'b1, 2'b10, 68'h22); tick();
        offer(1'b1, 2'b10, 68'h33); tick();
        offer(1'b0, 2'b00, '0);
        check("stream_first_valid", 128'(out_valid), 1);
        check("stream_first_data", 128'(out_data), 128'h11);
        check("stream_peak_occ", 128'(occupancy), 3);
        tick();
        check("stream_second", 128'(out_data), 128'h22);
        tick();
        check("stream_third", 128'(out_data), 128'h33);
        tick();
        check("stream_empty", 128'(out_valid), 0);

        // Backpressure: fill, hold, release one
        out_ready = 1'b0;
        offer(1'b1, 2'b01, 68'hA1); tick();
        offer(1'b1, 2'b01, 68'hA2); tick();
        offer(1'b1, 2'b01, 68'hA3); tick();
        offer(1'b1, 2'b01, 68'hA4);
        check("bp_full_ready", 128'(in_ready), 0);
        check("bp_full_occ", 128'(occupancy), 3);
        check("bp_head", 128'(out_data), 128'hA1);
        tick();
        check("bp_hold", 128'(out_data), 128'hA1);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 128'(in_ready), 1);
        tick();
        out_ready = 1'b0;
        offer(1'b0, 2'b00, '0);
        check("bp_next_head", 128'(out_data), 128'hA2);
        check("bp_occ_after", 128'(occupancy), 3);
        out_ready = 1'b1;
        repeat (3) tick();
        check("bp_drained", 128'(occupancy), 0);

        // Single entry collapses forward under a stall
        out_ready = 1'b0;
        offer(1'b1, 2'b10, 68'h55); tick();
        offer(1'b0, 2'b00, '0);
        check("collapse_e1_valid", 128'(out_valid), 0);
        check("collapse_e1_ready", 128'(in_ready), 1);
        tick();
        check("collapse_e2_ready", 128'(in_ready), 1);
        tick();
        check("collapse_arrived", 128'(out_valid), 1);
        check("collapse_data", 128'(out_data), 128'h55);
        check("collapse_ready", 128'(in_ready), 1);
        out_ready = 1'b1;
        tick();

        // Flush with simultaneous input and output handshakes
        out_ready = 1'b0;
        offer(1'b1, 2'b11, 68'hF1); tick();
        offer(1'b1, 2'b11, 68'hF2); tick();
        offer(1'b1, 2'b11, 68'hF3); tick();
        offer(1'b1, 2'b11, 68'hF4);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_in_ready", 128'(in_ready), 0);
        check("flush_out_valid_d", 128'(out_valid), 0);
        tick();
        flush = 1'b0;
        offer(1'b0, 2'b00, '0);
        check("post_flush_valid", 128'(out_valid), 0);
        check("post_flush_ctrl", 128'(out_ctrl), 0);
        check("post_flush_occ", 128'(occupancy), 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        offer(1'b1, 2'b11, 68'h61); tick();
        offer(1'b1, 2'b11, 68'h62); tick();
        offer(1'b0, 2'b00, '0);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 128'(out_valid), 0);
        check("arst_out_ctrl", 128'(out_ctrl), 0);
        check("arst_out_data", 128'(out_data), 0);
        check("arst_occ", 128'(occupancy), 0);
        tick(); tick();
        rst = 1'b0;
        out_ready = 1'b1;
        offer(1'b1, 2'b10, 68'h77); tick();
        offer(1'b0, 2'b00, '0);
        check("arst_first_accept", 128'(occupancy), 1);
        tick(); tick();
        check("arst_emerge_valid", 128'(out_valid), 1);
        check("arst_emerge_data", 128'(out_data), 128'h77);
        tick();

        // DEPTH=1: bubble zeroing and single-cycle latency
        b_in_valid = 1'b0; b_in_ctrl = 2'b11; b_in_data = 68'hFFFF;
        tick();
        check("b_bubble_ctrl", 128'(b_out_ctrl), 0);
        check("b_bubble_data", 128'(b_out_data), 0);
        check("b_bubble_occ", 128'(b_occ), 0);
        b_in_valid = 1'b1; b_in_ctrl = 2'b01; b_in_data = 68'h99;
        tick();
        check("b_pass_valid", 128'(b_out_valid), 1);
        check("b_pass_data", 128'(b_out_data), 128'h99);
        check("b_pass_ctrl", 128'(b_out_ctrl), 128'h1);
        check("b_full_ready", 128'(b_in_ready), 0);
        b_in_valid = 1'b0; b_in_ctrl = 2'b11; b_out_ready = 1'b1;
        tick();
        check("b_drain_valid", 128'(b_out_valid), 0);
        check("b_drain_data", 128'(b_out_data), 0);
        check("b_drain_occ", 128'(b_occ), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            offer(1'($urandom_range(0, 1)), 2'($urandom),
                  {4'($urandom), 32'($urandom), 32'($urandom)});
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush = 1'b0;
        offer(1'b0, 2'b00, '0);
        out_ready = 1'b1;

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            tick();
            waited++;
        end
        check("drain_done", 128'(exp_q.size()), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
